// File: rtl/ref_mb_loader.sv
// Writer side of the FME reference-pixel store: accepts one raster-order 16x16 macroblock
// per bank into a ping-pong pair of banks and hands completed banks to the half-pel reader.
module ref_mb_loader #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned MB_DIM = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mb_ready,
  input  logic              mb_release,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic [ADDR_W:0]   fill_count,
  output logic              frame_err
);

  localparam int unsigned Depth = MB_DIM * MB_DIM;
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(Depth - 1);

  logic [PIX_W-1:0]  mem [2][Depth];
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [1:0]        full_d;

  logic accept;
  logic at_end;
  logic complete;
  logic early_last;
  logic release_ok;

  // Writer stalls whenever the bank it targets still belongs to the reader.
  assign in_ready   = !full[wr_bank];
  assign mb_ready   = full[rd_bank];
  assign fill_count = {1'b0, wr_ptr};

  assign accept     = in_valid && in_ready;
  assign at_end     = (wr_ptr == LastPtr);
  assign complete   = accept && at_end;
  assign early_last = accept && in_last && !at_end;
  assign release_ok = mb_release && full[rd_bank];

  // Release and completion can never target the same bank, so both may apply in one cycle.
  always_comb begin
    full_d = full;
    if (release_ok) full_d[rd_bank] = 1'b0;
    if (complete)   full_d[wr_bank] = 1'b1;
  end

  // Write pointer, bank selectors, full flags and the sticky framing error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      frame_err <= 1'b0;
    end else begin
      full <= full_d;
      if (release_ok) rd_bank <= ~rd_bank;
      if (complete) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
        if (!in_last) frame_err <= 1'b1;
      end else if (early_last) begin
        // Short MB: drop the partial fill and restart the same bank.
        wr_ptr    <= '0;
        frame_err <= 1'b1;
      end else if (accept) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
    end
  end

  // Pixel storage; contents are intentionally left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (accept && !rst) mem[wr_bank][wr_ptr] <= in_data;
  end

  // Registered read port, sampled every cycle from the current read bank.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: tb/tb_ref_mb_loader.sv
// Randomised self-checking bench for ref_mb_loader against a queue-of-macroblocks model.
module tb_ref_mb_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       mb_ready;
  logic       mb_release = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [8:0] fill_count;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  ref_mb_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mb_ready   (mb_ready),
    .mb_release (mb_release),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .fill_count (fill_count),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Model: completed macroblocks wait in a queue (at most two), the one being loaded is a list.
  typedef logic [7:0] mb_t [256];
  mb_t        mbq [$];
  logic [7:0] part [$];
  mb_t        head;
  mb_t        tmp_mb;
  logic       m_err;
  logic       m_acc;
  logic [7:0] exp_rd;
  logic       exp_rd_ok;
  logic [7:0] ref_px [256];

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    mb_release = 1'b0;
    @(posedge clk);
    mbq.delete();
    part.delete();
    m_err = 1'b0;
    exp_rd = 8'h00;
    exp_rd_ok = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the clock, and advance the model the same way.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic rel,
                      input logic [7:0] ra);
    logic rel_eff;
    in_valid = v;
    in_data = d;
    in_last = l;
    mb_release = rel;
    rd_addr = ra;
    m_acc = v && (mbq.size() < 2);
    rel_eff = rel && (mbq.size() > 0);
    if (mbq.size() > 0) begin
      head = mbq[0];
      exp_rd = head[ra];
      exp_rd_ok = 1'b1;
    end else begin
      exp_rd_ok = 1'b0;
    end
    @(posedge clk);
    if (rel_eff) void'(mbq.pop_front());
    if (m_acc) begin
      if (part.size() == 255) begin
        part.push_back(d);
        for (int i = 0; i < 256; i++) tmp_mb[i] = part[i];
        mbq.push_back(tmp_mb);
        part.delete();
        if (!l) m_err = 1'b1;
      end else if (l) begin
        m_err = 1'b1;
        part.delete();
      end else begin
        part.push_back(d);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (mb_ready !== 1'b0) begin errors++;
      $display("FAIL reset_mb_ready got %b want 0", mb_ready); end
    checks++; if (fill_count !== 9'd0) begin errors++;
      $display("FAIL reset_fill_count got %0d want 0", fill_count); end
    checks++; if (frame_err !== 1'b0) begin errors++;
      $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (rd_data !== 8'h00) begin errors++;
      $display("FAIL reset_rd_data got %h want 00", rd_data); end
  endtask

  task automatic test_single_mb();
    do_reset();
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 8'(k), k == 255, 1'b0, 8'h00);
      if (k < 255) begin
        checks++; if (fill_count !== 9'(part.size()) || mb_ready !== 1'b0) begin errors++;
          $display("FAIL single_fill k=%0d got cnt=%0d rdy=%b want cnt=%0d rdy=0",
                   k, fill_count, mb_ready, part.size()); end
      end
    end
    checks++; if (mb_ready !== 1'b1) begin errors++;
      $display("FAIL single_mb_ready got %b want 1", mb_ready); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL single_in_ready got %b want 1", in_ready); end
    checks++; if (frame_err !== 1'b0) begin errors++;
      $display("FAIL single_frame_err got %b want 0", frame_err); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h37);
    checks++; if (rd_data !== 8'h37) begin errors++;
      $display("FAIL single_read got %h want 37", rd_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 512; k++) begin
      step(1'b1, (k < 256) ? 8'(k) : 8'(511 - k), (k % 256) == 255, 1'b0, 8'h00);
      checks++; if (in_ready !== (mbq.size() < 2)) begin errors++;
        $display("FAIL b2b_in_ready k=%0d got %b want %b", k, in_ready, mbq.size() < 2); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL b2b_stall got %b want 0", in_ready); end
    for (int k = 0; k < 3; k++) step(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
    checks++; if (fill_count !== 9'd0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL b2b_stalled_fill got cnt=%0d rdy=%b want cnt=0 rdy=0",
               fill_count, in_ready); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    checks++; if (in_ready !== 1'b1 || mb_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_after_release got in=%b mb=%b want in=1 mb=1", in_ready, mb_ready); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h10);
    checks++; if (rd_data !== 8'hEF) begin errors++;
      $display("FAIL b2b_read_mb1 got %h want ef", rd_data); end
  endtask

  task automatic test_gaps();
    int cnt;
    int cyc;
    logic [7:0] d;
    logic [7:0] base;
    do_reset();
    cnt = 0;
    cyc = 0;
    while (cnt < 256 && cyc < 3000) begin
      d = 8'($urandom);
      step(1'($urandom_range(0, 1)), d, cnt == 255, 1'b0, 8'($urandom));
      if (m_acc) begin
        ref_px[cnt] = d;
        cnt++;
      end
      cyc++;
      checks++; if (fill_count !== 9'(part.size())) begin errors++;
        $display("FAIL gaps_fill_count cyc=%0d got %0d want %0d", cyc, fill_count, part.size());
      end
    end
    if (cnt < 256) begin
      errors++;
      $display("FAIL gaps_timeout accepted %0d want 256", cnt);
    end
    checks++; if (mb_ready !== 1'b1) begin errors++;
      $display("FAIL gaps_mb_ready got %b want 1", mb_ready); end
    base = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, base + 8'(i));
      checks++; if (rd_data !== ref_px[base + 8'(i)]) begin errors++;
        $display("FAIL gaps_readback addr=%h got %h want %h", base + 8'(i), rd_data,
                 ref_px[base + 8'(i)]); end
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    for (int k = 0; k <= 100; k++) step(1'b1, 8'($urandom), k == 100, 1'b0, 8'h00);
    checks++; if (frame_err !== 1'b1 || fill_count !== 9'd0 || mb_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_mb got err=%b cnt=%0d mb=%b want err=1 cnt=0 mb=0",
               frame_err, fill_count, mb_ready); end
    for (int k = 0; k < 256; k++) step(1'b1, 8'($urandom), k == 255, 1'b0, 8'h00);
    checks++; if (mb_ready !== 1'b1 || frame_err !== m_err) begin errors++;
      $display("FAIL clean_after_short got mb=%b err=%b want mb=1 err=%b",
               mb_ready, frame_err, m_err); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'($urandom));
      checks++; if (!exp_rd_ok || rd_data !== exp_rd) begin errors++;
        $display("FAIL clean_read got %h want %h", rd_data, exp_rd); end
    end
    do_reset();
    for (int k = 0; k < 256; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
    checks++; if (mb_ready !== 1'b1 || frame_err !== 1'b1) begin errors++;
      $display("FAIL missing_last got mb=%b err=%b want mb=1 err=1", mb_ready, frame_err); end
  endtask

  task automatic test_release_edge();
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    checks++; if (fill_count !== 9'd10 || mb_ready !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_release got cnt=%0d mb=%b in=%b want cnt=10 mb=0 in=1",
               fill_count, mb_ready, in_ready); end
    for (int k = 10; k < 256; k++) step(1'b1, 8'(k), k == 255, 1'b0, 8'h00);
    for (int k = 0; k < 255; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'($urandom), 1'b1, 1'b1, 8'h00);
    checks++; if (mb_ready !== 1'b1 || in_ready !== 1'b1 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL release_with_completion got mb=%b in=%b err=%b want 1 1 0",
               mb_ready, in_ready, frame_err); end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'($urandom));
      checks++; if (!exp_rd_ok || rd_data !== exp_rd) begin errors++;
        $display("FAIL release_new_bank_read got %h want %h", rd_data, exp_rd); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(1'b1, 8'h00, 1'b1, 1'b0, 8'h00);
    checks++; if (frame_err !== 1'b1) begin errors++;
      $display("FAIL mid_pre_err got %b want 1", frame_err); end
    for (int k = 0; k < 256; k++) step(1'b1, 8'(k + 1), k == 255, 1'b0, 8'h20);
    for (int k = 0; k < 180; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 8'h20);
    checks++; if (fill_count !== 9'd180 || rd_data !== 8'h21) begin errors++;
      $display("FAIL mid_pre_state got cnt=%0d rd=%h want cnt=180 rd=21", fill_count, rd_data);
    end
    do_reset();
    checks++; if (in_ready !== 1'b1 || mb_ready !== 1'b0 || fill_count !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset_ctl got in=%b mb=%b cnt=%0d want in=1 mb=0 cnt=0",
               in_ready, mb_ready, fill_count); end
    checks++; if (frame_err !== 1'b0 || rd_data !== 8'h00) begin errors++;
      $display("FAIL mid_reset_data got err=%b rd=%h want err=0 rd=00", frame_err, rd_data); end
  endtask

  initial begin
    test_reset();
    test_single_mb();
    test_back_to_back();
    test_gaps();
    test_frame_err();
    test_release_edge();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
